// File: rtl/pipelined_cla_adder.sv
// Two-stage carry-lookahead adder/subtractor with valid/ready handshake.
// Stage 1 adds the low half, stage 2 the high half from the registered carry.
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int H  = WIDTH / 2;
  localparam int NG = H / GROUP;

  // Half-width CLA: returns {carry_out, sum}
  function automatic logic [H:0] cla(
    input logic [H-1:0] x,
    input logic [H-1:0] y,
    input logic         c0
  );
    logic [H-1:0]  g;
    logic [H-1:0]  p;
    logic [H:0]    c;
    logic [NG-1:0] gg;
    logic [NG-1:0] gp;
    logic [NG:0]   gc;
    logic          t;
    g = x & y;
    p = x ^ y;
    for (int k = 0; k < NG; k++) begin
      gg[k] = 1'b0;
      gp[k] = 1'b1;
      for (int j = 0; j < GROUP; j++) begin
        gg[k] = g[k*GROUP+j] | (p[k*GROUP+j] & gg[k]);
        gp[k] = gp[k] & p[k*GROUP+j];
      end
    end
    // Group carries as flat sum-of-products of c0
    gc[0] = c0;
    for (int k = 1; k <= NG; k++) begin
      gc[k] = c0;
      for (int m = 0; m < k; m++) gc[k] = gc[k] & gp[m];
      for (int j = 0; j < k; j++) begin
        t = gg[j];
        for (int m = j + 1; m < k; m++) t = t & gp[m];
        gc[k] = gc[k] | t;
      end
    end
    c = '0;
    for (int k = 0; k < NG; k++) begin
      c[k*GROUP] = gc[k];
      for (int j = 0; j < GROUP; j++)
        c[k*GROUP+j+1] = g[k*GROUP+j] | (p[k*GROUP+j] & c[k*GROUP+j]);
    end
    c[H] = gc[NG];
    return {c[H], p ^ c[H-1:0]};
  endfunction

  logic         v1;
  logic         v2;
  logic         c1;
  logic [H-1:0] lo1;
  logic [H-1:0] ah1;
  logic [H-1:0] bh1;
  logic         adv1;
  logic         adv2;
  logic [WIDTH-1:0] bx;
  logic         ce;
  logic [H:0]   lo_sum;
  logic [H:0]   hi_sum;
  logic         hmsb;
  logic [WIDTH-1:0] s_nxt;

  always_comb begin
    bx     = sub ? ~b : b;
    ce     = sub | cin;
    lo_sum = cla(a[H-1:0], bx[H-1:0], ce);
    hi_sum = cla(ah1, bh1, c1);
    // carry into the MSB recovered from the sum bit
    hmsb   = hi_sum[H-1] ^ ah1[H-1] ^ bh1[H-1];
    s_nxt  = {hi_sum[H-1:0], lo1};
  end

  assign adv2      = !v2 || out_ready;
  assign adv1      = !v1 || adv2;
  assign in_ready  = adv1;
  assign out_valid = v2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      c1   <= 1'b0;
      lo1  <= '0;
      ah1  <= '0;
      bh1  <= '0;
      s    <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else begin
      if (adv1) begin
        v1 <= in_valid;
        if (in_valid) begin
          lo1 <= lo_sum[H-1:0];
          c1  <= lo_sum[H];
          ah1 <= a[WIDTH-1:H];
          bh1 <= bx[WIDTH-1:H];
        end
      end
      if (adv2) begin
        v2 <= v1;
        if (v1) begin
          s    <= s_nxt;
          cout <= hi_sum[H];
          ovf  <= hmsb ^ hi_sum[H];
          zero <= (s_nxt == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: directed corners plus a random
// handshake sweep on 8/16/32-bit instances against an arithmetic model.
module tb_pipelined_cla_adder;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        sub;

  logic        ir8, ir16, ir32;
  logic        ov8, ov16, ov32;
  logic [7:0]  s8;
  logic [15:0] s16;
  logic [31:0] s32;
  logic        co8, co16, co32;
  logic        of8, of16, of32;
  logic        z8, z16, z32;

  beat_t q[$];
  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pipelined_cla_adder #(.WIDTH(8), .GROUP(4)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir8),
    .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub),
    .out_valid(ov8), .out_ready(out_ready),
    .s(s8), .cout(co8), .ovf(of8), .zero(z8));

  pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir16),
    .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub),
    .out_valid(ov16), .out_ready(out_ready),
    .s(s16), .cout(co16), .ovf(of16), .zero(z16));

  pipelined_cla_adder #(.WIDTH(32), .GROUP(4)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir32),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov32), .out_ready(out_ready),
    .s(s32), .cout(co32), .ovf(of32), .zero(z32));

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {zero, ovf, cout, s} for a w-bit adder
  function automatic logic [34:0] ref_res(input beat_t t, input int w);
    longint unsigned m, aw, bw, sum, sv;
    logic co, o, z, sa, sb, ss;
    m   = (64'd1 << w) - 1;
    aw  = {32'd0, t.a} & m;
    bw  = (t.sub ? ~{32'd0, t.b} : {32'd0, t.b}) & m;
    sum = aw + bw + ((t.sub || t.cin) ? 64'd1 : 64'd0);
    sv  = sum & m;
    co  = sum[w];
    sa  = aw[w-1];
    sb  = bw[w-1];
    ss  = sv[w-1];
    o   = (sa == sb) && (ss != sa);
    z   = (sv == 0);
    return {z, o, co, sv[31:0]};
  endfunction

  task automatic cmp_w(input string nm, input int w, input beat_t t,
                       input logic [31:0] so, input logic co,
                       input logic oo, input logic zo, input logic vo);
    logic [34:0] r;
    r = ref_res(t, w);
    chk({nm, "_valid"}, vo, 1);
    chk({nm, "_s"}, so, r[31:0]);
    chk({nm, "_cout"}, co, r[32]);
    chk({nm, "_ovf"}, oo, r[33]);
    chk({nm, "_zero"}, zo, r[34]);
  endtask

  // One clock: sample handshake just after the falling edge
  task automatic step(output bit acc);
    beat_t t;
    #1;
    acc = in_valid && ir16;
    if (ov16) begin
      if (q.size() == 0) begin
        chk("spurious_out", ov16, 0);
      end else begin
        t = q[0];
        cmp_w("w8", 8, t, {24'd0, s8}, co8, of8, z8, ov8);
        cmp_w("w16", 16, t, {16'd0, s16}, co16, of16, z16, ov16);
        cmp_w("w32", 32, t, s32, co32, of32, z32, ov32);
        if (out_ready) void'(q.pop_front());
      end
    end
    if (acc) begin
      t.a = a;
      t.b = b;
      t.sub = sub;
      t.cin = cin;
      q.push_back(t);
    end
    @(negedge clk);
  endtask

  task automatic directed(input string tag, input logic [15:0] da,
                          input logic [15:0] db, input logic dc,
                          input logic ds, input logic [15:0] es,
                          input logic ec, input logic eo, input logic ez);
    bit acc;
    a = {16'd0, da};
    b = {16'd0, db};
    cin = dc;
    sub = ds;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step(acc);
    chk({tag, "_acc"}, acc, 1);
    in_valid = 1'b0;
    chk({tag, "_lat1"}, ov16, 0);
    step(acc);
    chk({tag, "_lat2"}, ov16, 1);
    chk({tag, "_s"}, s16, es);
    chk({tag, "_cout"}, co16, ec);
    chk({tag, "_ovf"}, of16, eo);
    chk({tag, "_zero"}, z16, ez);
    step(acc);
  endtask

  initial begin
    bit acc;
    int sent;
    logic [31:0] bpa[4];
    logic [31:0] bpb[4];
    bpa = '{32'h0001_1111, 32'h00FF_2222, 32'h7FFF_8000, 32'hFFFF_FFFF};
    bpb = '{32'h0002_0001, 32'h0001_00FF, 32'h0001_0001, 32'h0000_0001};

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    sub = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ov", ov16, 0);
    chk("rst_s", s16, 0);
    chk("rst_cout", co16, 0);
    chk("rst_ovf", of16, 0);
    chk("rst_zero", z16, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_inready", ir16, 1);
    @(negedge clk);

    directed("carry_mid", 16'h00FF, 16'h0001, 0, 0, 16'h0100, 0, 0, 0);
    directed("add_ovf", 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, 0);
    directed("add_wrap", 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, 1);
    directed("sub_neg", 16'h0005, 16'h0007, 1, 1, 16'hFFFE, 0, 0, 0);
    directed("sub_ovf", 16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1, 0);

    // Back-pressure: four beats against a stalled sink
    out_ready = 1'b0;
    sent = 0;
    for (int c = 0; c < 30 && sent < 4; c++) begin
      if (c == 2 || c == 3) chk("bp_inready_low", ir16, 0);
      if (c == 4) out_ready = 1'b1;
      a = bpa[sent];
      b = bpb[sent];
      sub = sent[0];
      cin = sent[1];
      in_valid = 1'b1;
      step(acc);
      if (acc) sent++;
    end
    chk("bp_sent", sent, 4);
    in_valid = 1'b0;
    for (int c = 0; c < 10 && q.size() > 0; c++) step(acc);
    chk("bp_drained", q.size(), 0);
    repeat (3) step(acc);

    // Reset with both stages full
    out_ready = 1'b0;
    in_valid = 1'b1;
    a = 32'h1234_5678;
    b = 32'h0F0F_0F0F;
    repeat (3) step(acc);
    chk("full_ov", ov16, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_ov16", ov16, 0);
    chk("arst_ov8", ov8, 0);
    chk("arst_ov32", ov32, 0);
    chk("arst_s", s32, 0);
    chk("arst_flags", {co32, of32, z32}, 0);
    q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_inready", ir16, 1);
    @(negedge clk);
    out_ready = 1'b1;
    repeat (5) step(acc);
    chk("post_rst_empty", ov16, 0);

    // Random sweep with random handshake
    for (int c = 0; c < 1500; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: a = 32'hFFFF_FFFF;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h8000_8080;
        3: b = a;
        default: ;
      endcase
      sub = $urandom_range(0, 1) != 0;
      cin = $urandom_range(0, 1) != 0;
      step(acc);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && q.size() > 0; c++) step(acc);
    chk("rand_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand/sum width; SHALL be even, >= 8 and a multiple of 2*GROUP.
REQ-002 Parameter GROUP, default 4, carry-lookahead group size in bits; group carries SHALL be computed by lookahead equations, not by bit-serial ripple.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  block accepts the beat this cycle.
REQ-007 a, b  input  WIDTH  operands.
REQ-008 cin  input  1  carry-in; in subtract mode it is ignored and forced to 1.
REQ-009 sub  input  1  0 = a+b+cin, 1 = a-b (a + ~b + 1).
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  downstream accepts the result this cycle.
REQ-012 s  output  WIDTH  sum/difference, modulo 2^WIDTH.
REQ-013 cout  output  1  carry out of the MSB (in subtract mode, 1 = no borrow).
REQ-014 ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.
REQ-015 zero  output  1  s == 0.

Function
REQ-016 Two register stages: S1 computes the lower WIDTH/2 bits and their carry-out, and registers them with the upper operand halves (b already conditionally inverted) and the effective cin/sub; S2 computes the upper half from the registered carry and registers s, cout, ovf and zero.
REQ-017 Each stage holds one valid bit; a beat is accepted on in_valid && in_ready and delivered on out_valid && out_ready.
REQ-018 Latency SHALL be exactly 2 cycles from acceptance to out_valid when out_ready is held high; throughput SHALL be one beat per cycle.
REQ-019 S2 SHALL advance when it is empty or out_ready=1; S1 SHALL advance when it is empty or S2 advances; in_ready SHALL equal the S1 advance condition (combinational from out_ready and the valid bits, never from in_valid).
REQ-020 While out_valid=1 and out_ready=0, s, cout, ovf and zero SHALL hold stable and no beat SHALL be lost or duplicated; with both stages full, in_ready SHALL be 0.
REQ-021 Simultaneous accept and deliver in the same cycle SHALL be supported at full occupancy (pass-through with no bubble).
REQ-022 Beats SHALL leave in acceptance order; each beat's sub/cin SHALL travel with it, so mixed add/sub streams are handled beat by beat.
REQ-023 Wrap-around: results SHALL be truncated to WIDTH bits with the carry reported only on cout.
REQ-024 Data registers need not be reset; only the valid bits and outputs named in REQ-025 are reset state.

Reset
REQ-025 rst_n=0 SHALL immediately (asynchronously) clear both valid bits and force out_valid=0, s=0, cout=0, ovf=0, zero=0; in_ready SHALL be 1 in the first cycle after deassertion.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight beats; no stale beat SHALL appear after release.

Verification
REQ-027 WIDTH=16, out_ready=1: accept a=0x00FF, b=0x0001, sub=0, cin=0 -> exactly 2 cycles later out_valid=1, s=0x0100, cout=0, ovf=0, zero=0 (checks the S1->S2 carry).
REQ-028 a=0x7FFF, b=0x0001, add -> s=0x8000, ovf=1, cout=0; a=0xFFFF, b=0x0001, add -> s=0x0000, cout=1, zero=1, ovf=0.
REQ-029 Subtract a=0x0005, b=0x0007, cin=1 -> s=0xFFFE, cout=0, ovf=0; a=0x8000, b=0x0001 -> s=0x7FFF, ovf=1, cout=1.
REQ-030 Back-pressure: stream 4 beats with out_ready=0 -> in_ready drops after 2 accepts and the outputs stay stable; raise out_ready -> all 4 results arrive in order, with no loss or duplication.
REQ-031 Reset pulse while both stages are full -> out_valid=0 at once; after release, in_ready=1 and no old result appears.
REQ-032 Random sweep for WIDTH=8, 16 and 32 with random valid/ready toggling -> every result matches the reference model (a±b+cin, flags) in order.
